mc_sequencer: RTL and testbench

- Multi-cycle sequencer for the single-ALU MIPS datapath: fetch, decode, execute, writeback.
- Fetches opcodes over a req/ack handshake with instruction memory.
- Generates per-phase strobes: IR load, PC increment, ALU enable/select, register-file write.
- Tracks retired instructions; flags illegal opcodes and fetch timeouts; halts on the HALT opcode.

---
 rtl/mc_pkg.sv | 22 ++
 rtl/mc_op_decode.sv | 30 +++
 rtl/mc_sequencer.sv | 115 +++++++++++
 tb/tb_mc_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle MIPS sequencer.
// Opcode values are plain ints so each user can size them to its own OP_W.
package mc_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_HALT
   } state_t;

   localparam int OP_ADD  = 0;
   localparam int OP_SUB  = 1;
   localparam int OP_HALT = 63;

   localparam logic [1:0] ALU_NOP = 2'b00;
   localparam logic [1:0] ALU_ADD = 2'b01;
   localparam logic [1:0] ALU_SUB = 2'b10;

endpackage

// File: rtl/mc_op_decode.sv
// Combinational opcode decode: ALU select plus legal/halt classification.
// HALT counts as legal; only unrecognised opcodes clear legal.
module op_decode
   import mc_pkg::*;
#(
   parameter int OP_W = 6
) (
   input  logic [OP_W-1:0] opcode,
   output logic [1:0]      alu_ctrl,
   output logic            legal,
   output logic            is_halt
);

   always_comb begin
      alu_ctrl = ALU_NOP;
      legal    = 1'b0;
      is_halt  = 1'b0;
      if (opcode == OP_W'(OP_ADD)) begin
         alu_ctrl = ALU_ADD;
         legal    = 1'b1;
      end else if (opcode == OP_W'(OP_SUB)) begin
         alu_ctrl = ALU_SUB;
         legal    = 1'b1;
      end else if (opcode == OP_W'(OP_HALT)) begin
         legal   = 1'b1;
         is_halt = 1'b1;
      end
   end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle fetch/decode/exec/writeback sequencer for the single-ALU datapath.
// Every output except ir_load is a decode of registered state and opcode.
module mc_sequencer
   import mc_pkg::*;
#(
   parameter int OP_W          = 6,
   parameter int CNT_W         = 16,
   parameter int FETCH_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             imem_req,
   input  logic             imem_ack,
   input  logic [OP_W-1:0]  imem_opcode,
   output logic             ir_load,
   output logic             pc_inc,
   output logic             alu_en,
   output logic [1:0]       alu_ctrl,
   output logic             regwrite,
   output logic             busy,
   output logic             illegal,
   output logic             timeout,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   localparam int WC_W = $clog2(FETCH_TIMEOUT + 1);

   state_t          state, state_n;
   logic [OP_W-1:0] opc;
   logic [WC_W-1:0] wcnt;
   logic            to_set;
   logic [1:0]      dec_ctrl;
   logic            dec_legal, dec_halt;

   op_decode #(.OP_W(OP_W)) u_dec (
      .opcode   (opc),
      .alu_ctrl (dec_ctrl),
      .legal    (dec_legal),
      .is_halt  (dec_halt)
   );

   always_comb begin
      state_n  = state;
      to_set   = 1'b0;
      imem_req = 1'b0;
      ir_load  = 1'b0;
      pc_inc   = 1'b0;
      alu_en   = 1'b0;
      alu_ctrl = ALU_NOP;
      regwrite = 1'b0;
      busy     = 1'b0;
      illegal  = 1'b0;
      halted   = 1'b0;
      unique case (state)
         S_IDLE: if (start) state_n = S_FETCH;
         S_FETCH: begin
            busy     = 1'b1;
            imem_req = 1'b1;
            ir_load  = imem_ack;
            // an ack on the limit cycle takes priority over the fault
            if (imem_ack) state_n = S_DECODE;
            else if (wcnt == WC_W'(FETCH_TIMEOUT - 1)) begin
               to_set  = 1'b1;
               state_n = S_HALT;
            end
         end
         S_DECODE: begin
            busy = 1'b1;
            if (dec_halt) state_n = S_HALT;
            else if (dec_legal) state_n = S_EXEC;
            else begin
               illegal = 1'b1;
               pc_inc  = 1'b1;
               state_n = S_FETCH;
            end
         end
         S_EXEC: begin
            busy     = 1'b1;
            alu_en   = 1'b1;
            alu_ctrl = dec_ctrl;
            state_n  = S_WB;
         end
         S_WB: begin
            busy     = 1'b1;
            alu_ctrl = dec_ctrl;
            regwrite = 1'b1;
            pc_inc   = 1'b1;
            state_n  = S_FETCH;
         end
         S_HALT: halted = 1'b1;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         opc     <= '0;
         wcnt    <= '0;
         retired <= '0;
         timeout <= 1'b0;
      end else begin
         state <= state_n;
         if (ir_load) opc <= imem_opcode;
         // counter only runs across consecutive no-ack FETCH cycles
         if (state == S_FETCH && !imem_ack) wcnt <= wcnt + WC_W'(1);
         else wcnt <= '0;
         if (to_set) timeout <= 1'b1;
         if (state == S_WB && retired != '1) retired <= retired + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed-vector bench for mc_sequencer; a second CNT_W=2 copy shares the stimulus
// so counter saturation can be observed alongside the full-width instance.
module tb_mc_sequencer;

   localparam int FT = 15;

   // observed vector: {req, ir_load, pc_inc, alu_en, alu_ctrl[1:0], regwrite, busy, illegal, timeout, halted}
   localparam logic [10:0] IDLE    = 11'b0_0_0_0_00_0_0_0_0_0;
   localparam logic [10:0] F_ACK   = 11'b1_1_0_0_00_0_1_0_0_0;
   localparam logic [10:0] F_WAIT  = 11'b1_0_0_0_00_0_1_0_0_0;
   localparam logic [10:0] DEC     = 11'b0_0_0_0_00_0_1_0_0_0;
   localparam logic [10:0] DEC_ILL = 11'b0_0_1_0_00_0_1_1_0_0;
   localparam logic [10:0] EX_ADD  = 11'b0_0_0_1_01_0_1_0_0_0;
   localparam logic [10:0] EX_SUB  = 11'b0_0_0_1_10_0_1_0_0_0;
   localparam logic [10:0] WB_ADD  = 11'b0_0_1_0_01_1_1_0_0_0;
   localparam logic [10:0] WB_SUB  = 11'b0_0_1_0_10_1_1_0_0_0;
   localparam logic [10:0] HLT     = 11'b0_0_0_0_00_0_0_0_0_1;
   localparam logic [10:0] HLT_TO  = 11'b0_0_0_0_00_0_0_0_1_1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        imem_ack = 1'b0;
   logic [5:0]  imem_opcode = '0;
   logic        imem_req, ir_load, pc_inc, alu_en, regwrite, busy, illegal, timeout, halted;
   logic [1:0]  alu_ctrl;
   logic [15:0] retired;
   logic        s_req, s_irl, s_pci, s_alue, s_rw, s_busy, s_ill, s_to, s_halt;
   logic [1:0]  s_ctrl;
   logic [1:0]  s_retired;
   logic [10:0] obs;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mc_sequencer #(.OP_W(6), .CNT_W(16), .FETCH_TIMEOUT(FT)) dut (
      .clk(clk), .rst(rst), .start(start), .imem_req(imem_req), .imem_ack(imem_ack),
      .imem_opcode(imem_opcode), .ir_load(ir_load), .pc_inc(pc_inc), .alu_en(alu_en),
      .alu_ctrl(alu_ctrl), .regwrite(regwrite), .busy(busy), .illegal(illegal),
      .timeout(timeout), .halted(halted), .retired(retired)
   );

   mc_sequencer #(.OP_W(6), .CNT_W(2), .FETCH_TIMEOUT(FT)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .imem_req(s_req), .imem_ack(imem_ack),
      .imem_opcode(imem_opcode), .ir_load(s_irl), .pc_inc(s_pci), .alu_en(s_alue),
      .alu_ctrl(s_ctrl), .regwrite(s_rw), .busy(s_busy), .illegal(s_ill),
      .timeout(s_to), .halted(s_halt), .retired(s_retired)
   );

   assign obs = {imem_req, ir_load, pc_inc, alu_en, alu_ctrl, regwrite, busy, illegal, timeout, halted};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // one clock: drive inputs just after the edge, check mid-cycle
   task automatic cyc(input string tag, input logic st, input logic ak,
                      input logic [5:0] op, input logic [10:0] exp);
      @(posedge clk); #1;
      start = st; imem_ack = ak; imem_opcode = op;
      @(negedge clk);
      chk(tag, 32'(obs), 32'(exp));
   endtask

   task automatic do_reset;
      @(posedge clk); #1;
      rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_opcode = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_outs", 32'(obs), 32'(IDLE));
      chk("rst_ret", 32'(retired), 0);
   endtask

   task automatic exec_add(input string tag);
      cyc({tag, "_f"}, 0, 1, 6'd0, F_ACK);
      cyc({tag, "_d"}, 0, 0, 6'd0, DEC);
      cyc({tag, "_e"}, 0, 0, 6'd0, EX_ADD);
      cyc({tag, "_w"}, 0, 0, 6'd0, WB_ADD);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      // zero-wait ADD, SUB, HALT
      do_reset();
      cyc("t1_go", 1, 0, 6'd0, IDLE);
      exec_add("t1_add");
      cyc("t1_f_sub", 0, 1, 6'd1, F_ACK);
      chk("t1_ret1", 32'(retired), 1);
      cyc("t1_d_sub", 0, 0, 6'd0, DEC);
      cyc("t1_e_sub", 0, 0, 6'd0, EX_SUB);
      cyc("t1_w_sub", 0, 0, 6'd0, WB_SUB);
      cyc("t1_f_hlt", 0, 1, 6'd63, F_ACK);
      cyc("t1_d_hlt", 0, 0, 6'd0, DEC);
      cyc("t1_halt", 1, 0, 6'd0, HLT);
      chk("t1_ret2", 32'(retired), 2);
      cyc("t1_halt_ign", 1, 1, 6'd0, HLT);

      // three wait cycles before ack
      do_reset();
      cyc("t2_go", 1, 0, 6'd0, IDLE);
      for (int i = 0; i < 3; i++) cyc("t2_wait", 0, 0, 6'd0, F_WAIT);
      exec_add("t2_add");
      cyc("t2_next", 0, 0, 6'd0, F_WAIT);
      chk("t2_ret", 32'(retired), 1);

      // illegal opcode skipped
      do_reset();
      cyc("t3_go", 1, 0, 6'd0, IDLE);
      cyc("t3_f_ill", 0, 1, 6'd5, F_ACK);
      cyc("t3_d_ill", 0, 0, 6'd0, DEC_ILL);
      cyc("t3_f_next", 0, 1, 6'd0, F_ACK);
      chk("t3_ret0", 32'(retired), 0);
      cyc("t3_d", 0, 0, 6'd0, DEC);
      cyc("t3_e", 0, 0, 6'd0, EX_ADD);
      cyc("t3_w", 0, 0, 6'd0, WB_ADD);
      cyc("t3_after", 0, 0, 6'd0, F_WAIT);
      chk("t3_ret1", 32'(retired), 1);

      // fetch timeout: FT cycles with no ack
      do_reset();
      cyc("t4_go", 1, 0, 6'd0, IDLE);
      for (int i = 0; i < FT; i++) cyc("t4_wait", 0, 0, 6'd0, F_WAIT);
      cyc("t4_fault", 0, 0, 6'd0, HLT_TO);
      cyc("t4_sticky", 1, 1, 6'd0, HLT_TO);

      // ack on the limit cycle wins
      do_reset();
      cyc("t4b_go", 1, 0, 6'd0, IDLE);
      for (int i = 0; i < FT - 1; i++) cyc("t4b_wait", 0, 0, 6'd0, F_WAIT);
      exec_add("t4b_add");
      cyc("t4b_next", 0, 0, 6'd0, F_WAIT);

      // reset during EXEC with a coincident ack
      do_reset();
      cyc("t5_go", 1, 0, 6'd0, IDLE);
      exec_add("t5_add");
      cyc("t5_f_sub", 0, 1, 6'd1, F_ACK);
      cyc("t5_d_sub", 0, 0, 6'd0, DEC);
      cyc("t5_e_sub", 0, 0, 6'd0, EX_SUB);
      chk("t5_ret_pre", 32'(retired), 1);
      @(posedge clk); #1;
      rst = 1'b1; imem_ack = 1'b1; imem_opcode = 6'd0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t5_rst_outs", 32'(obs), 32'(IDLE));
      chk("t5_rst_ret", 32'(retired), 0);
      cyc("t5_idle_ack", 0, 1, 6'd0, IDLE);
      cyc("t5_go2", 1, 0, 6'd0, IDLE);
      exec_add("t5_add2");
      cyc("t5_next", 0, 0, 6'd0, F_WAIT);
      chk("t5_ret_post", 32'(retired), 1);

      // saturation on the 2-bit counter copy
      do_reset();
      chk("t6_sat_rst", 32'(s_retired), 0);
      cyc("t6_go", 1, 0, 6'd0, IDLE);
      for (int i = 0; i < 5; i++) exec_add("t6_add");
      cyc("t6_next", 0, 0, 6'd0, F_WAIT);
      chk("t6_ret_wide", 32'(retired), 5);
      chk("t6_ret_sat", 32'(s_retired), 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
